// File: rtl/periodic_tick.sv
// periodic_tick: programmable clock divider that emits a wrapping tick
// sequence number on a stb/ack stream, counts ticks lost while the consumer
// stalls, and accepts new periods through its own stb/ack stream.
module periodic_tick #(
  parameter int          WIDTH          = 16,
  parameter int          PERIOD_WIDTH   = 32,
  parameter int unsigned DEFAULT_PERIOD = 50000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PERIOD_WIDTH-1:0] input_period,
  input  logic                    input_period_stb,
  output logic                    input_period_ack,
  output logic [WIDTH-1:0]        output_tick,
  output logic                    output_tick_stb,
  input  logic                    output_tick_ack,
  output logic [WIDTH-1:0]        overrun
);

  localparam logic [PERIOD_WIDTH-1:0] RESET_PERIOD = PERIOD_WIDTH'(DEFAULT_PERIOD);
  localparam logic [PERIOD_WIDTH-1:0] ONE_PERIOD   = PERIOD_WIDTH'(1);
  localparam logic [WIDTH-1:0]        ONE_COUNT    = WIDTH'(1);

  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic [PERIOD_WIDTH-1:0] prescaler_q, prescaler_d;
  logic [WIDTH-1:0]        seq_q, seq_d;
  logic [WIDTH-1:0]        tick_q, tick_d;
  logic [WIDTH-1:0]        overrun_q, overrun_d;
  logic                    tickStb_q, tickStb_d;
  logic                    periodAck_q, periodAck_d;

  logic periodXfer;
  logic periodNonZero;
  logic terminalCount;
  logic tickEvent;
  logic tickXfer;

  // Decode handshakes and the terminal count; a period write steals the event.
  always_comb begin
    periodXfer    = input_period_stb & periodAck_q;
    periodNonZero = |period_q;
    terminalCount = periodNonZero && (prescaler_q == (period_q - ONE_PERIOD));
    tickEvent     = terminalCount & ~periodXfer;
    tickXfer      = tickStb_q & output_tick_ack;
  end

  // Period register and prescaler: a write restarts the count, zero pauses it.
  always_comb begin
    period_d    = period_q;
    prescaler_d = prescaler_q;
    if (periodXfer) begin
      period_d    = input_period;
      prescaler_d = '0;
    end else if (!periodNonZero || terminalCount) begin
      prescaler_d = '0;
    end else begin
      prescaler_d = prescaler_q + ONE_PERIOD;
    end
  end

  // Period ack is a registered one-cycle pulse, so a held stb is acked every other cycle.
  always_comb begin
    periodAck_d = input_period_stb & ~periodAck_q;
  end

  // Tick output stream: load a fresh tick when the slot is free, otherwise count the loss.
  always_comb begin
    seq_d     = seq_q;
    tick_d    = tick_q;
    tickStb_d = tickStb_q;
    overrun_d = overrun_q;
    if (tickEvent) begin
      seq_d = seq_q + ONE_COUNT;
      if (!tickStb_q || output_tick_ack) begin
        tick_d    = seq_q;
        tickStb_d = 1'b1;
      end else if (overrun_q != '1) begin
        overrun_d = overrun_q + ONE_COUNT;
      end
    end else if (tickXfer) begin
      tickStb_d = 1'b0;
    end
  end

  // State registers with synchronous reset that also discards any pending tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_q    <= RESET_PERIOD;
      prescaler_q <= '0;
      seq_q       <= '0;
      tick_q      <= '0;
      overrun_q   <= '0;
      tickStb_q   <= 1'b0;
      periodAck_q <= 1'b0;
    end else begin
      period_q    <= period_d;
      prescaler_q <= prescaler_d;
      seq_q       <= seq_d;
      tick_q      <= tick_d;
      overrun_q   <= overrun_d;
      tickStb_q   <= tickStb_d;
      periodAck_q <= periodAck_d;
    end
  end

  assign input_period_ack = periodAck_q;
  assign output_tick      = tick_q;
  assign output_tick_stb  = tickStb_q;
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_periodic_tick.sv
// Testbench for periodic_tick: directed scenarios with literal expectations
// plus a cycle-level behavioural model compared against the DUT every cycle.
module tb_periodic_tick;

  localparam int W     = 4;
  localparam int PW    = 32;
  localparam int DEFP  = 5;
  localparam int MODV  = 16;
  localparam int SATV  = 15;

  logic          clk;
  logic          rst;
  logic [PW-1:0] pVal;
  logic          pStb;
  logic          pAck;
  logic [W-1:0]  tick;
  logic          tickStb;
  logic          tAck;
  logic [W-1:0]  overrunOut;

  int nCompared;
  int nMismatched;
  int cyc;

  // Behavioural model state, expressed as elapsed cycles within a period
  int mPeriod;
  int mPhase;
  int mSeq;
  int mTick;
  int mOverrun;
  bit mStb;
  bit mPack;
  bit modelValid;

  periodic_tick #(
    .WIDTH(W),
    .PERIOD_WIDTH(PW),
    .DEFAULT_PERIOD(DEFP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .input_period(pVal),
    .input_period_stb(pStb),
    .input_period_ack(pAck),
    .output_tick(tick),
    .output_tick_stb(tickStb),
    .output_tick_ack(tAck),
    .overrun(overrunOut)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic ps, input logic [PW-1:0] pv,
                               input logic ack);
    rst  = r;
    pStb = ps;
    pVal = pv;
    tAck = ack;
  endtask

  task automatic advance(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Hold reset across one edge; returns in cycle 0 with reset released
  task automatic doReset(input logic ack);
    applyStimulus(1'b1, 1'b0, '0, ack);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  // Model update at every edge, then compare the DUT against it just after
  initial begin
    modelValid = 1'b0;
    forever begin
      bit r, ps, ack, xfer, evt, newPack;
      int pv;
      @(posedge clk);
      r   = rst;
      ps  = pStb;
      pv  = int'(pVal);
      ack = tAck;
      if (r) begin
        modelValid = 1'b1;
        mPeriod = DEFP; mPhase = 0; mSeq = 0; mTick = 0;
        mOverrun = 0; mStb = 1'b0; mPack = 1'b0;
      end else if (modelValid) begin
        xfer    = ps && mPack;
        evt     = !xfer && (mPeriod != 0) && (mPhase == mPeriod - 1);
        newPack = ps && !mPack;
        if (evt) begin
          if (!mStb || ack) begin
            mTick = mSeq;
            mStb  = 1'b1;
          end else begin
            mOverrun = (mOverrun + 1 > SATV) ? SATV : mOverrun + 1;
          end
          mSeq = (mSeq + 1) % MODV;
        end else if (mStb && ack) begin
          mStb = 1'b0;
        end
        if (xfer) begin
          mPeriod = pv;
          mPhase  = 0;
        end else if (mPeriod == 0) begin
          mPhase = 0;
        end else begin
          mPhase = (mPhase + 1) % mPeriod;
        end
        mPack = newPack;
      end
      #1;
      if (modelValid) begin
        checkOutput("model_stb", int'(tickStb), int'(mStb));
        checkOutput("model_tick", int'(tick), mTick);
        checkOutput("model_overrun", int'(overrunOut), mOverrun);
        checkOutput("model_pack", int'(pAck), int'(mPack));
      end
    end
  end

  // Directed scenarios with hand-computed expectations
  initial begin
    nCompared   = 0;
    nMismatched = 0;
    cyc         = 0;
    applyStimulus(1'b1, 1'b0, '0, 1'b1);

    $display("[TB] scenario: default period, ack high");
    doReset(1'b1);
    advance(4);  checkOutput("s1_stb_c4", int'(tickStb), 0);
    advance(1);  checkOutput("s1_stb_c5", int'(tickStb), 1);
                 checkOutput("s1_tick_c5", int'(tick), 0);
    advance(1);  checkOutput("s1_stb_c6", int'(tickStb), 0);
    advance(4);  checkOutput("s1_tick_c10", int'(tick), 1);
                 checkOutput("s1_stb_c10", int'(tickStb), 1);
    advance(5);  checkOutput("s1_tick_c15", int'(tick), 2);
                 checkOutput("s1_overrun_c15", int'(overrunOut), 0);

    $display("[TB] scenario: stalled consumer");
    doReset(1'b0);
    advance(5);  checkOutput("s2_tick_c5", int'(tick), 0);
    advance(16); checkOutput("s2_overrun_c21", int'(overrunOut), 3);
                 checkOutput("s2_tick_c21", int'(tick), 0);
                 checkOutput("s2_stb_c21", int'(tickStb), 1);
    advance(1);  tAck = 1'b1;
    advance(1);  checkOutput("s2_stb_c23", int'(tickStb), 0);
    advance(2);  checkOutput("s2_stb_c25", int'(tickStb), 1);
                 checkOutput("s2_tick_c25", int'(tick), 4);

    $display("[TB] scenario: period writes 2, 0, 1 and saturation");
    doReset(1'b1);
    advance(6);  applyStimulus(1'b0, 1'b1, 32'd2, 1'b1);
                 checkOutput("s3_pack_c6", int'(pAck), 0);
    advance(1);  checkOutput("s3_pack_c7", int'(pAck), 1);
    advance(1);  pStb = 1'b0;
                 checkOutput("s3_pack_c8", int'(pAck), 0);
    advance(2);  checkOutput("s3_stb_c10", int'(tickStb), 1);
                 checkOutput("s3_tick_c10", int'(tick), 1);
    advance(1);  checkOutput("s3_stb_c11", int'(tickStb), 0);
    advance(1);  checkOutput("s3_tick_c12", int'(tick), 2);
    advance(3);  applyStimulus(1'b0, 1'b1, 32'd0, 1'b1);
    advance(2);  pStb = 1'b0;
    advance(8);  checkOutput("s3_stb_paused_c25", int'(tickStb), 0);
    advance(5);  applyStimulus(1'b0, 1'b1, 32'd1, 1'b1);
    advance(2);  pStb = 1'b0;
    advance(1);  checkOutput("s3_tick_c33", int'(tick), 5);
                 checkOutput("s3_stb_c33", int'(tickStb), 1);
    advance(11); checkOutput("s3_tick_wrap_c44", int'(tick), 0);
    advance(6);  tAck = 1'b0;
    advance(20); checkOutput("s3_overrun_sat_c70", int'(overrunOut), 15);

    $display("[TB] scenario: reset while tick pending");
    doReset(1'b0);
    checkOutput("s4_stb_after_rst", int'(tickStb), 0);
    checkOutput("s4_overrun_after_rst", int'(overrunOut), 0);
    tAck = 1'b1;
    advance(4);  checkOutput("s4_stb_c4", int'(tickStb), 0);
    advance(1);  checkOutput("s4_stb_c5", int'(tickStb), 1);
                 checkOutput("s4_tick_c5", int'(tick), 0);
    doReset(1'b0);
    advance(16); checkOutput("s4_overrun_c16", int'(overrunOut), 2);
    doReset(1'b1);
    checkOutput("s4_stb_mid", int'(tickStb), 0);
    checkOutput("s4_tick_mid", int'(tick), 0);
    checkOutput("s4_overrun_mid", int'(overrunOut), 0);
    advance(5);  checkOutput("s4_stb_again_c5", int'(tickStb), 1);

    $display("[TB] scenario: period write on terminal count");
    doReset(1'b1);
    advance(3);  applyStimulus(1'b0, 1'b1, 32'd3, 1'b1);
    advance(1);  checkOutput("s5_pack_c4", int'(pAck), 1);
    advance(1);  pStb = 1'b0;
                 checkOutput("s5_stb_c5", int'(tickStb), 0);
    advance(2);  checkOutput("s5_stb_c7", int'(tickStb), 0);
    advance(1);  checkOutput("s5_stb_c8", int'(tickStb), 1);
                 checkOutput("s5_tick_c8", int'(tick), 0);
    advance(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
